prog_ctr: RTL and testbench
===========================

Name: prog_ctr

Overview:
- Program counter / fetch-sequencing stage. Drives the instruction memory address.
- Consumes the 10-bit absolute branch target produced by the branch-target lookup table.
- Sequences one program per Start request. Reports Running/Done to the top-level testbench handshake.
- Keeps a retired-instruction count for performance reporting.

Parameters:
PC_W, 10, width of program counter and branch target
CNT_W, 16, width of retired-instruction counter

Ports:
Clk  input  1  system clock; all state updates on rising edge
Reset  input  1  asynchronous, active-high reset
Start  input  1  level-sampled request to begin a program; honoured in IDLE or DONE only
StartAddr  input  PC_W  entry address loaded on accepted Start
Stall  input  1  freeze PC, counter and state this cycle
Branch  input  1  taken-branch request from control/ALU flag logic
Target  input  PC_W  absolute branch target from lookup table, valid when Branch=1
Halt  input  1  decoded halt instruction at current PC
PC  output  PC_W  current instruction address
Running  output  1  high while in RUN
Done  output  1  high while in DONE
InstrCount  output  CNT_W  instructions retired in current/last program
WrapErr  output  1  sticky: sequential increment wrapped past max address

Behaviour:
- Reset (async, any state, mid-run included):
  - State=IDLE, PC=0, Running=0, Done=0, InstrCount=0, WrapErr=0.
  - Release takes effect on the next Clk edge.
- States: IDLE, RUN, DONE. Running and Done are decoded from state (Moore). No combinational input-to-output paths.
- IDLE:
  - Start=1 -> RUN; PC<=StartAddr; InstrCount<=0; WrapErr<=0.
  - Otherwise hold. Stall, Branch and Halt are ignored.
- RUN: one action per edge, in strict priority order:
  1. Stall=1: hold PC, InstrCount and state. Branch and Halt are ignored that cycle; the sender re-presents them.
  2. Halt=1: -> DONE; PC holds (points at halt instruction); InstrCount+1 (halt counts as retired).
  3. Branch=1: PC<=Target; InstrCount+1.
  4. Otherwise: PC<=PC+1 modulo 2^PC_W; InstrCount+1.
  - Start is ignored in RUN.
- Wrap-around: a sequential increment from all-ones to 0 sets WrapErr (sticky until Reset or an accepted Start). PC still wraps and execution continues. A branch to 0 does not set WrapErr.
- InstrCount saturates at all-ones and never wraps.
- Target=0 is a legal destination; no special handling.
- DONE:
  - PC, InstrCount and WrapErr hold.
  - Start=1 -> RUN with the same loads as from IDLE (back-to-back programs, no IDLE visit).
  - Stall, Branch and Halt are ignored.
- Latency:
  - PC reflects a branch/increment one edge after the request is sampled.
  - Running rises one edge after Start is sampled.
  - Done rises one edge after Halt is sampled.
- Halt and Branch both high (not stalled): Halt wins; no redirect.

Test Plan:
- Reset asserted mid-RUN at PC=37, asynchronously between edges -> PC=0, Running=0, Done=0, InstrCount=0 before the next edge.
- Start with StartAddr=4, run 3 cycles, then Branch with Target=64 -> PC sequence 4,5,6,7,64; InstrCount=4 after the branch edge.
- In RUN at PC=73: Stall=1 for 2 cycles with Branch=1, Target=131 held -> PC stays 73 and InstrCount frozen. Stall=0 -> PC=131 next edge.
- Halt and Branch both high at PC=166 -> state DONE, PC=166, Done=1, Running=0. Later Start with StartAddr=177 -> RUN, PC=177, InstrCount=0, Done=0.
- StartAddr=1022, no branches -> PC 1022, 1023, 0, 1; WrapErr=1 from the edge producing 0. WrapErr stays set until the next accepted Start.
- Force InstrCount near saturation (run 65540 non-stalled cycles with a branch loop to Target=270) -> InstrCount=65535 and holds; no rollover to 0.

Source files
------------

// File: rtl/prog_ctr.sv
// prog_ctr: program counter / fetch sequencer.
// Sequences one program per accepted Start: PC is loaded with StartAddr and
// then advances by +1 or jumps to Target on a taken branch. It stops on a
// decoded halt. A saturating counter tracks retired instructions, and a
// sticky flag records a sequential wrap past the top of the address space.
module prog_ctr #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [PC_W-1:0]  StartAddr,
    input  logic             Stall,
    input  logic             Branch,
    input  logic [PC_W-1:0]  Target,
    input  logic             Halt,
    output logic [PC_W-1:0]  PC,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] InstrCount,
    output logic             WrapErr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;

    // Derived values used by the sequencer.
    logic [PC_W-1:0]   pc_inc;
    logic              pc_at_top;
    logic [CNT_W-1:0]  cnt_next;

    // Sequential successor address and saturating retire count.
    // The successor wraps modulo 2^PC_W. The retire count holds at all-ones.
    always_comb begin
        pc_inc    = PC + PC_W'(1);
        pc_at_top = &PC;
        cnt_next  = (&InstrCount) ? InstrCount : InstrCount + CNT_W'(1);
    end

    // Sequencer FSM. Running and Done are registered alongside the state, so
    // they always match it and have no combinational path from any input.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            PC         <= '0;
            InstrCount <= '0;
            WrapErr    <= 1'b0;
            Running    <= 1'b0;
            Done       <= 1'b0;
        end else begin
            case (state)
                // IDLE and DONE respond only to Start. DONE keeps the last
                // program's PC, count and wrap flag visible until then.
                IDLE, DONE: begin
                    if (Start) begin
                        state      <= RUN;
                        PC         <= StartAddr;
                        InstrCount <= '0;
                        WrapErr    <= 1'b0;
                        Running    <= 1'b1;
                        Done       <= 1'b0;
                    end
                end

                // A stall freezes everything. The sender re-presents Branch
                // or Halt after the stall, so dropping them here is safe.
                RUN: begin
                    if (!Stall) begin
                        InstrCount <= cnt_next;
                        if (Halt) begin
                            // PC keeps pointing at the halt instruction.
                            state   <= DONE;
                            Running <= 1'b0;
                            Done    <= 1'b1;
                        end else if (Branch) begin
                            // A branch to 0 is an ordinary redirect, not a wrap.
                            PC <= Target;
                        end else begin
                            PC <= pc_inc;
                            if (pc_at_top)
                                WrapErr <= 1'b1;
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    Running <= 1'b0;
                    Done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_ctr.sv
// tb_prog_ctr: directed vector table, asynchronous reset, saturation and
// randomized run against an arithmetic reference model.
module tb_prog_ctr;

    localparam int PC_W  = 10;
    localparam int CNT_W = 16;
    localparam int PC_MOD  = 1 << PC_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic             Start = 1'b0;
    logic [PC_W-1:0]  StartAddr = '0;
    logic             Stall = 1'b0;
    logic             Branch = 1'b0;
    logic [PC_W-1:0]  Target = '0;
    logic             Halt = 1'b0;
    logic [PC_W-1:0]  PC;
    logic             Running;
    logic             Done;
    logic [CNT_W-1:0] InstrCount;
    logic             WrapErr;

    prog_ctr #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
        .Stall(Stall), .Branch(Branch), .Target(Target), .Halt(Halt),
        .PC(PC), .Running(Running), .Done(Done),
        .InstrCount(InstrCount), .WrapErr(WrapErr)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0=idle, 1=run, 2=done.
    int m_mode, m_pc, m_cnt, m_wrap;

    typedef struct {
        bit st; int sa; bit sl; bit br; int tg; bit hl;
        int pc; bit run; bit dn; int cnt; bit wr;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".PC"}, int'(PC), m_pc);
        check({tag, ".Running"}, int'(Running), int'(m_mode == 1));
        check({tag, ".Done"}, int'(Done), int'(m_mode == 2));
        check({tag, ".InstrCount"}, int'(InstrCount), m_cnt);
        check({tag, ".WrapErr"}, int'(WrapErr), m_wrap);
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = 0; m_cnt = 0; m_wrap = 0;
    endtask

    // Advance the model by the rules for one edge with the given inputs.
    task automatic model_step(input bit st, input int sa, input bit sl,
                              input bit br, input int tg, input bit hl);
        if (m_mode != 1) begin
            if (st) begin
                m_mode = 1; m_pc = sa; m_cnt = 0; m_wrap = 0;
            end
        end else if (!sl) begin
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            if (hl) m_mode = 2;
            else if (br) m_pc = tg;
            else begin
                if (m_pc == PC_MOD - 1) m_wrap = 1;
                m_pc = (m_pc + 1) % PC_MOD;
            end
        end
    endtask

    // Apply inputs, clock one edge, and sample 1 time unit after the edge.
    task automatic cyc(input bit st, input int sa, input bit sl,
                       input bit br, input int tg, input bit hl);
        Start = st; StartAddr = sa[PC_W-1:0]; Stall = sl;
        Branch = br; Target = tg[PC_W-1:0]; Halt = hl;
        model_step(st, sa, sl, br, tg, hl);
        @(posedge Clk);
        #1;
    endtask

    task automatic addv(input bit st, input int sa, input bit sl, input bit br,
                        input int tg, input bit hl, input int pc, input bit run,
                        input bit dn, input int cnt, input bit wr);
        vec_t v;
        v.st = st; v.sa = sa; v.sl = sl; v.br = br; v.tg = tg; v.hl = hl;
        v.pc = pc; v.run = run; v.dn = dn; v.cnt = cnt; v.wr = wr;
        vecs.push_back(v);
    endtask

    initial begin
        string tag;
        // Directed table: inputs for one edge, then the outputs after that edge.
        //   st  sa   sl br tg   hl | pc  run dn cnt wr
        addv(0, 9,    1, 1, 55,  1,   0,   0, 0, 0, 0); // IDLE ignores stall/branch/halt
        addv(1, 4,    1, 0, 0,   0,   4,   1, 0, 0, 0); // start accepted despite stall
        addv(0, 0,    0, 0, 0,   0,   5,   1, 0, 1, 0);
        addv(0, 0,    0, 0, 0,   0,   6,   1, 0, 2, 0);
        addv(0, 0,    0, 0, 0,   0,   7,   1, 0, 3, 0);
        addv(0, 0,    0, 1, 64,  0,   64,  1, 0, 4, 0); // branch to 64
        addv(0, 0,    0, 1, 73,  0,   73,  1, 0, 5, 0);
        addv(0, 0,    1, 1, 131, 0,   73,  1, 0, 5, 0); // stall holds
        addv(0, 0,    1, 1, 131, 0,   73,  1, 0, 5, 0);
        addv(0, 0,    0, 1, 131, 0,   131, 1, 0, 6, 0); // branch taken after stall
        addv(0, 0,    0, 1, 166, 0,   166, 1, 0, 7, 0);
        addv(0, 0,    0, 1, 200, 1,   166, 0, 1, 8, 0); // halt beats branch
        addv(0, 0,    1, 1, 5,   1,   166, 0, 1, 8, 0); // DONE ignores these
        addv(1, 177,  0, 0, 0,   0,   177, 1, 0, 0, 0); // restart from DONE
        addv(1, 3,    0, 0, 0,   0,   178, 1, 0, 1, 0); // start ignored in RUN
        addv(0, 0,    0, 1, 1022,0,   1022,1, 0, 2, 0);
        addv(0, 0,    0, 0, 0,   0,   1023,1, 0, 3, 0);
        addv(0, 0,    0, 0, 0,   0,   0,   1, 0, 4, 1); // wrap sets WrapErr
        addv(0, 0,    0, 0, 0,   0,   1,   1, 0, 5, 1);
        addv(0, 0,    0, 1, 0,   0,   0,   1, 0, 6, 1); // branch to 0 is legal
        addv(0, 0,    0, 0, 0,   1,   0,   0, 1, 7, 1); // WrapErr holds in DONE
        addv(1, 0,    0, 0, 0,   0,   0,   1, 0, 0, 0); // start clears WrapErr
        addv(0, 0,    0, 1, 0,   0,   0,   1, 0, 1, 0); // branch to 0: no wrap

        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check("reset.PC", int'(PC), 0);
        check("reset.Running", int'(Running), 0);
        check("reset.Done", int'(Done), 0);
        check("reset.InstrCount", int'(InstrCount), 0);
        check("reset.WrapErr", int'(WrapErr), 0);
        Reset = 1'b0;

        foreach (vecs[i]) begin
            cyc(vecs[i].st, vecs[i].sa, vecs[i].sl, vecs[i].br, vecs[i].tg, vecs[i].hl);
            tag = $sformatf("vec%0d", i);
            check({tag, ".PC"}, int'(PC), vecs[i].pc);
            check({tag, ".Running"}, int'(Running), int'(vecs[i].run));
            check({tag, ".Done"}, int'(Done), int'(vecs[i].dn));
            check({tag, ".InstrCount"}, int'(InstrCount), vecs[i].cnt);
            check({tag, ".WrapErr"}, int'(WrapErr), int'(vecs[i].wr));
        end

        // Asynchronous reset mid-run at PC=37, observed before the next edge.
        cyc(0, 0, 0, 1, 37, 0);
        check("pre_areset.PC", int'(PC), 37);
        #3 Reset = 1'b1;
        #1;
        model_reset();
        check_model("areset");
        #1 Reset = 1'b0;
        cyc(0, 0, 0, 0, 0, 0);
        check_model("post_areset_idle");

        // Saturation: loop on Target=270 well past the counter limit.
        cyc(1, 270, 0, 0, 0, 0);
        for (int i = 0; i < CNT_MAX - 1; i++) cyc(0, 0, 0, 1, 270, 0);
        check("sat.below", int'(InstrCount), CNT_MAX - 1);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 1, 270, 0);
            check("sat.hold", int'(InstrCount), CNT_MAX);
            check("sat.PC", int'(PC), 270);
        end

        // Randomized run against the reference model.
        for (int i = 0; i < 3000; i++) begin
            bit st, sl, br, hl;
            int sa, tg;
            st = ($urandom_range(99) < 6);
            sl = ($urandom_range(99) < 25);
            br = ($urandom_range(99) < 20);
            hl = ($urandom_range(99) < 3);
            sa = ($urandom_range(1) == 1) ? int'($urandom_range(PC_MOD - 1))
                                          : int'($urandom_range(PC_MOD - 1, PC_MOD - 9));
            tg = ($urandom_range(3) == 0) ? int'($urandom_range(PC_MOD - 1, PC_MOD - 4))
                                          : int'($urandom_range(PC_MOD - 1));
            cyc(st, sa, sl, br, tg, hl);
            check_model($sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
